// File: rtl/qkv_spike_pingpong_buffer_pkg.sv
// Shared defaults and channel indices for the QKV spike-line ping-pong buffer.
package qkv_spike_pingpong_buffer_pkg;

  localparam int SYSTOLIC_UNIT_NUM = 16;
  localparam int TIME_STEPS        = 4;
  localparam int QKV_DATA_W        = 2 * SYSTOLIC_UNIT_NUM * TIME_STEPS;
  localparam int QKV_FRAME_LEN     = 768;
  localparam int QKV_AW            = 10;
  localparam int QKV_NUM_CH        = 3;

  typedef enum logic [1:0] {
    QKV_Q = 2'd0,
    QKV_K = 2'd1,
    QKV_V = 2'd2
  } qkv_ch_e;

endpackage

// File: rtl/qkv_spike_pingpong_buffer_spike_bank_ram.sv
// Simple dual-port spike-line RAM holding two banks; the bank bit is the address MSB.
module spike_bank_ram
  import qkv_spike_pingpong_buffer_pkg::*;
#(
  parameter int DATA_W = QKV_DATA_W,
  parameter int AW     = QKV_AW
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              i_we,
  input  logic [AW:0]       i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW:0]       i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [2**(AW+1)];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  always_ff @(posedge s_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  always_comb rdata_d = mem[i_raddr];

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/qkv_spike_pingpong_buffer.sv
// Double-buffered Q/K/V spike-line store between the linear and attention stages.
// Define QKV_BUF_OUTREG_EN to add an output register on o_rd_data (read latency 2).
module qkv_spike_pingpong_buffer
  import qkv_spike_pingpong_buffer_pkg::*;
#(
  parameter int NUM_CH    = QKV_NUM_CH,
  parameter int DATA_W    = QKV_DATA_W,
  parameter int FRAME_LEN = QKV_FRAME_LEN,
  parameter int AW        = QKV_AW
) (
  input  logic                     s_clk,
  input  logic                     s_rst,
  input  logic [NUM_CH*DATA_W-1:0] i_wr_data,
  input  logic [NUM_CH-1:0]        i_wr_valid,
  output logic [NUM_CH-1:0]        o_wr_ready,
  input  logic [NUM_CH*AW-1:0]     i_rd_addr,
  output logic [NUM_CH*DATA_W-1:0] o_rd_data,
  output logic                     o_frame_ready,
  output logic                     o_rd_bank,
  input  logic                     i_frame_release,
  output logic                     o_overflow
);

  localparam int CW = AW + 1;

  logic              wr_bank_d, wr_bank_q;
  logic              rd_bank_d, rd_bank_q;
  logic [1:0]        full_d, full_q;
  logic [CW-1:0]     wcnt_d [NUM_CH];
  logic [CW-1:0]     wcnt_q [NUM_CH];
  logic              overflow_d, overflow_q;
  logic              frame_ready_d, frame_ready_q;
  logic [NUM_CH-1:0] ch_done;
  logic [NUM_CH-1:0] wr_en;
  logic              commit;
  logic              release_ok;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_done[c]    = (wcnt_q[c] == CW'(FRAME_LEN));
      o_wr_ready[c] = !full_q[wr_bank_q] && !ch_done[c];
    end
  end

  assign wr_en      = i_wr_valid & o_wr_ready;
  assign commit     = &ch_done;
  assign release_ok = i_frame_release && full_q[rd_bank_q];

  // Commit and release never target the same bank: the write bank is never full.
  always_comb begin
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    overflow_d = overflow_q | (|(i_wr_valid & ~o_wr_ready));
    for (int c = 0; c < NUM_CH; c++) begin
      wcnt_d[c] = commit ? '0 : wcnt_q[c] + CW'(wr_en[c]);
    end
    if (commit) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (release_ok) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    frame_ready_d = full_d[rd_bank_d];
  end

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      full_q        <= '0;
      overflow_q    <= 1'b0;
      frame_ready_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) wcnt_q[c] <= '0;
    end else begin
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      full_q        <= full_d;
      overflow_q    <= overflow_d;
      frame_ready_q <= frame_ready_d;
      for (int c = 0; c < NUM_CH; c++) wcnt_q[c] <= wcnt_d[c];
    end
  end

  assign o_frame_ready = frame_ready_q;
  assign o_rd_bank     = rd_bank_q;
  assign o_overflow    = overflow_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] ram_rdata;
    logic [AW:0]       waddr;
    logic [AW:0]       raddr;

    assign waddr = {wr_bank_q, wcnt_q[c][AW-1:0]};
    assign raddr = {rd_bank_q, i_rd_addr[c*AW +: AW]};

    spike_bank_ram #(
      .DATA_W (DATA_W),
      .AW     (AW)
    ) u_ram (
      .s_clk   (s_clk),
      .s_rst   (s_rst),
      .i_we    (wr_en[c]),
      .i_waddr (waddr),
      .i_wdata (i_wr_data[c*DATA_W +: DATA_W]),
      .i_raddr (raddr),
      .o_rdata (ram_rdata)
    );

`ifdef QKV_BUF_OUTREG_EN
    logic [DATA_W-1:0] rd_out_d, rd_out_q;

    always_comb rd_out_d = ram_rdata;

    always_ff @(posedge s_clk or posedge s_rst) begin
      if (s_rst) rd_out_q <= '0;
      else       rd_out_q <= rd_out_d;
    end

    assign o_rd_data[c*DATA_W +: DATA_W] = rd_out_q;
`else
    assign o_rd_data[c*DATA_W +: DATA_W] = ram_rdata;
`endif
  end

endmodule

// File: tb/tb_qkv_spike_pingpong_buffer.sv
// Randomised bench for qkv_spike_pingpong_buffer against a frame-level reference model.
module tb_qkv_spike_pingpong_buffer;
  import qkv_spike_pingpong_buffer_pkg::*;

  localparam int NCH  = 3;
  localparam int DW   = 16;
  localparam int FLEN = 4;
  localparam int AW   = 2;
`ifdef QKV_BUF_OUTREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic              s_clk = 1'b0;
  logic              s_rst;
  logic [NCH*DW-1:0] i_wr_data;
  logic [NCH-1:0]    i_wr_valid;
  logic [NCH-1:0]    o_wr_ready;
  logic [NCH*AW-1:0] i_rd_addr;
  logic [NCH*DW-1:0] o_rd_data;
  logic              o_frame_ready;
  logic              o_rd_bank;
  logic              i_frame_release;
  logic              o_overflow;

  qkv_spike_pingpong_buffer #(
    .NUM_CH    (NCH),
    .DATA_W    (DW),
    .FRAME_LEN (FLEN),
    .AW        (AW)
  ) dut (
    .s_clk           (s_clk),
    .s_rst           (s_rst),
    .i_wr_data       (i_wr_data),
    .i_wr_valid      (i_wr_valid),
    .o_wr_ready      (o_wr_ready),
    .i_rd_addr       (i_rd_addr),
    .o_rd_data       (o_rd_data),
    .o_frame_ready   (o_frame_ready),
    .o_rd_bank       (o_rd_bank),
    .i_frame_release (i_frame_release),
    .o_overflow      (o_overflow)
  );

  always #5 s_clk = ~s_clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: lines of the frame being filled, committed frames by bank,
  // and frame counters (write bank = committed%2, read bank = released%2).
  logic [DW-1:0]     part [NCH][$];
  logic [DW-1:0]     frame_mem [2][NCH][FLEN];
  int                committed;
  int                released;
  int                cyc;
  logic              ovf_m;
  logic              hist_chk [16];
  logic [NCH*DW-1:0] hist_dat [16];

  function automatic logic [NCH-1:0] exp_ready();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++)
      r[c] = ((committed - released) < 2) && (part[c].size() < FLEN);
    return r;
  endfunction

  function automatic logic [NCH*AW-1:0] rand_addr();
    logic [NCH*AW-1:0] a;
    for (int c = 0; c < NCH; c++) a[c*AW +: AW] = AW'($urandom_range(0, FLEN-1));
    return a;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) part[c].delete();
    committed = 0;
    released  = 0;
    ovf_m     = 1'b0;
    for (int i = 0; i < 16; i++) hist_chk[i] = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic drive_cycle(input logic [NCH-1:0] v, input logic rel, input logic [NCH*AW-1:0] addr);
    logic [NCH-1:0]    rdy;
    logic [NCH*DW-1:0] d;
    logic [NCH*DW-1:0] ed;
    logic              commit_now;
    logic              rel_now;
    for (int c = 0; c < NCH; c++) d[c*DW +: DW] = DW'($urandom);
    i_wr_data       = d;
    i_wr_valid      = v;
    i_frame_release = rel;
    i_rd_addr       = addr;
    #1;
    rdy = exp_ready();
    n_chk++;
    if (o_wr_ready !== rdy) begin
      n_fail++;
      $display("FAIL wr_ready cycle %0d: got %b expected %b", cyc, o_wr_ready, rdy);
    end
    n_chk++;
    if (o_frame_ready !== (committed > released)) begin
      n_fail++;
      $display("FAIL frame_ready cycle %0d: got %b expected %b", cyc, o_frame_ready, committed > released);
    end
    n_chk++;
    if (o_rd_bank !== 1'(released % 2)) begin
      n_fail++;
      $display("FAIL rd_bank cycle %0d: got %b expected %b", cyc, o_rd_bank, 1'(released % 2));
    end
    n_chk++;
    if (o_overflow !== ovf_m) begin
      n_fail++;
      $display("FAIL overflow cycle %0d: got %b expected %b", cyc, o_overflow, ovf_m);
    end
    if (cyc >= RD_LAT && hist_chk[(cyc - RD_LAT) % 16]) begin
      n_chk++;
      if (o_rd_data !== hist_dat[(cyc - RD_LAT) % 16]) begin
        n_fail++;
        $display("FAIL rd_data cycle %0d: got %h expected %h", cyc, o_rd_data, hist_dat[(cyc - RD_LAT) % 16]);
      end
    end
    for (int c = 0; c < NCH; c++) ed[c*DW +: DW] = frame_mem[released % 2][c][addr[c*AW +: AW]];
    hist_chk[cyc % 16] = (committed > released);
    hist_dat[cyc % 16] = ed;
    commit_now = 1'b1;
    for (int c = 0; c < NCH; c++) if (part[c].size() != FLEN) commit_now = 1'b0;
    rel_now = rel && (committed > released);
    @(posedge s_clk);
    ovf_m = ovf_m | (|(v & ~rdy));
    for (int c = 0; c < NCH; c++) if (v[c] && rdy[c]) part[c].push_back(d[c*DW +: DW]);
    if (rel_now) released++;
    if (commit_now) begin
      for (int c = 0; c < NCH; c++) begin
        for (int l = 0; l < FLEN; l++) frame_mem[committed % 2][c][l] = part[c][l];
        part[c].delete();
      end
      committed++;
    end
    cyc++;
    @(negedge s_clk);
  endtask

  task automatic fill(input int tq, input int tk, input int tv);
    int             tgt [NCH];
    logic [NCH-1:0] v;
    logic [NCH-1:0] r;
    tgt[int'(QKV_Q)] = tq;
    tgt[int'(QKV_K)] = tk;
    tgt[int'(QKV_V)] = tv;
    for (int k = 0; k < 40; k++) begin
      r = exp_ready();
      for (int c = 0; c < NCH; c++) v[c] = r[c] && (part[c].size() < tgt[c]);
      if (v == '0) return;
      drive_cycle(v, 1'b0, rand_addr());
    end
    n_chk++;
    n_fail++;
    $display("FAIL fill_timeout: targets %0d/%0d/%0d not reached in 40 cycles", tq, tk, tv);
  endtask

  task automatic read_frame();
    logic [NCH*AW-1:0] a;
    for (int l = 0; l < FLEN; l++) begin
      for (int c = 0; c < NCH; c++) a[c*AW +: AW] = AW'((l + c) % FLEN);
      drive_cycle('0, 1'b0, a);
    end
    repeat (RD_LAT) drive_cycle('0, 1'b0, rand_addr());
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    i_wr_valid = '0;
    i_frame_release = 1'b0;
    @(posedge s_clk);
    @(negedge s_clk);
    s_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    s_rst = 1'b1;
    i_wr_data = '0;
    i_wr_valid = '0;
    i_rd_addr = '0;
    i_frame_release = 1'b0;
    repeat (2) @(posedge s_clk);
    @(negedge s_clk);
    #1;
    n_chk++;
    if (o_wr_ready !== 3'b111) begin n_fail++; $display("FAIL reset_ready: got %b expected 111", o_wr_ready); end
    n_chk++;
    if (o_frame_ready !== 1'b0) begin n_fail++; $display("FAIL reset_frame_ready: got %b expected 0", o_frame_ready); end
    n_chk++;
    if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", o_overflow); end
    n_chk++;
    if (o_rd_bank !== 1'b0) begin n_fail++; $display("FAIL reset_rd_bank: got %b expected 0", o_rd_bank); end
    n_chk++;
    if (o_rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", o_rd_data); end
    s_rst = 1'b0;
    model_reset();
  endtask

  task automatic test_full_frame();
    fill(FLEN, FLEN, FLEN);
    #1;
    n_chk++;
    if (o_wr_ready !== 3'b000) begin n_fail++; $display("FAIL ff_done_ready: got %b expected 000", o_wr_ready); end
    drive_cycle('0, 1'b0, rand_addr());
    #1;
    n_chk++;
    if (o_frame_ready !== 1'b1) begin n_fail++; $display("FAIL ff_frame_ready: got %b expected 1", o_frame_ready); end
    n_chk++;
    if (o_wr_ready !== 3'b111) begin n_fail++; $display("FAIL ff_ready_after_commit: got %b expected 111", o_wr_ready); end
    read_frame();
    drive_cycle('0, 1'b1, rand_addr());
    #1;
    n_chk++;
    if (o_rd_bank !== 1'b1) begin n_fail++; $display("FAIL ff_rd_bank: got %b expected 1", o_rd_bank); end
  endtask

  task automatic test_partial();
    fill(FLEN, 2, 0);
    #1;
    n_chk++;
    if (o_wr_ready !== 3'b110) begin n_fail++; $display("FAIL partial_ready: got %b expected 110", o_wr_ready); end
    drive_cycle('0, 1'b0, rand_addr());
    #1;
    n_chk++;
    if (o_frame_ready !== 1'b0) begin n_fail++; $display("FAIL partial_no_commit: got %b expected 0", o_frame_ready); end
    fill(FLEN, FLEN, FLEN);
    drive_cycle('0, 1'b0, rand_addr());
    #1;
    n_chk++;
    if (o_wr_ready !== 3'b111) begin n_fail++; $display("FAIL partial_ready_back: got %b expected 111", o_wr_ready); end
    n_chk++;
    if (o_frame_ready !== 1'b1) begin n_fail++; $display("FAIL partial_commit: got %b expected 1", o_frame_ready); end
    read_frame();
    drive_cycle('0, 1'b1, rand_addr());
  endtask

  task automatic test_ignored_release();
    logic rb;
    #1;
    rb = o_rd_bank;
    drive_cycle('0, 1'b1, rand_addr());
    #1;
    n_chk++;
    if (o_rd_bank !== rb) begin n_fail++; $display("FAIL ign_rel_rd_bank: got %b expected %b", o_rd_bank, rb); end
    n_chk++;
    if (o_frame_ready !== 1'b0) begin n_fail++; $display("FAIL ign_rel_frame_ready: got %b expected 0", o_frame_ready); end
  endtask

  task automatic test_simul_commit_release();
    logic rb;
    fill(FLEN, FLEN, FLEN);
    drive_cycle('0, 1'b0, rand_addr());
    fill(FLEN, FLEN, FLEN);
    #1;
    rb = o_rd_bank;
    drive_cycle('0, 1'b1, rand_addr());
    #1;
    n_chk++;
    if (o_frame_ready !== 1'b1) begin n_fail++; $display("FAIL simul_frame_ready: got %b expected 1", o_frame_ready); end
    n_chk++;
    if (o_rd_bank !== ~rb) begin n_fail++; $display("FAIL simul_rd_bank: got %b expected %b", o_rd_bank, ~rb); end
    n_chk++;
    if (o_wr_ready !== 3'b111) begin n_fail++; $display("FAIL simul_ready: got %b expected 111", o_wr_ready); end
    read_frame();
    drive_cycle('0, 1'b1, rand_addr());
  endtask

  task automatic test_overflow();
    do_reset();
    fill(FLEN, FLEN, FLEN);
    drive_cycle('0, 1'b0, rand_addr());
    fill(FLEN, FLEN, FLEN);
    drive_cycle('0, 1'b0, rand_addr());
    #1;
    n_chk++;
    if (o_wr_ready !== 3'b000) begin n_fail++; $display("FAIL ovf_stall_ready: got %b expected 000", o_wr_ready); end
    drive_cycle(3'b111, 1'b0, rand_addr());
    drive_cycle(3'b111, 1'b0, rand_addr());
    #1;
    n_chk++;
    if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", o_overflow); end
    drive_cycle('0, 1'b1, rand_addr());
    #1;
    n_chk++;
    if (o_wr_ready !== 3'b111) begin n_fail++; $display("FAIL ovf_ready_restored: got %b expected 111", o_wr_ready); end
    n_chk++;
    if (o_rd_bank !== 1'b1) begin n_fail++; $display("FAIL ovf_rd_bank: got %b expected 1", o_rd_bank); end
    read_frame();
  endtask

  task automatic test_reset_mid();
    fill(2, 2, 2);
    s_rst = 1'b1;
    #1;
    n_chk++;
    if (o_frame_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_frame_ready: got %b expected 0", o_frame_ready); end
    n_chk++;
    if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_overflow: got %b expected 0", o_overflow); end
    n_chk++;
    if (o_rd_bank !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_bank: got %b expected 0", o_rd_bank); end
    @(posedge s_clk);
    @(negedge s_clk);
    s_rst = 1'b0;
    model_reset();
    fill(FLEN, FLEN, FLEN);
    drive_cycle('0, 1'b0, rand_addr());
    #1;
    n_chk++;
    if (o_frame_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_commit: got %b expected 1", o_frame_ready); end
    read_frame();
    drive_cycle('0, 1'b1, rand_addr());
  endtask

  task automatic test_random();
    logic [NCH-1:0] v;
    for (int k = 0; k < 400; k++) begin
      v = NCH'($urandom);
      drive_cycle(v, ($urandom_range(0, 5) == 0), rand_addr());
    end
  endtask

  initial begin
    model_reset();
    cyc = 0;
    test_reset();
    test_full_frame();
    test_partial();
    test_ignored_release();
    test_simul_commit_release();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/qkv_spike_pingpong_buffer.md
Name: qkv_spike_pingpong_buffer

Overview:
- Parametrised, double-buffered spike-line store between the QKV linear stage and the attention stage.
- NUM_CH independent channels (default 3: Q, K, V). Each channel holds two banks of FRAME_LEN lines.
- The linear stage fills one bank while attention reads the other, so a new token frame can be written before the previous one is consumed.
- Per-channel valid/ready write handshake, frame-commit and frame-release bookkeeping, sticky overflow flag.

Parameters:
- NUM_CH, 3, number of channels (Q/K/V).
- DATA_W, 128, spike-line width (2*SYSTOLIC_UNIT_NUM*TIME_STEPS).
- FRAME_LEN, 768, lines per channel per frame; must be ≥2.
- AW, 10, line address width; 2**AW ≥ FRAME_LEN.

Ports:
- s_clk  in  1  clock.
- s_rst  in  1  reset, asynchronous, active-high.
- i_wr_data  in  NUM_CH*DATA_W  write lines; channel c occupies bits [c*DATA_W +: DATA_W].
- i_wr_valid  in  NUM_CH  per-channel write strobe.
- o_wr_ready  out  NUM_CH  per-channel write acceptance.
- i_rd_addr  in  NUM_CH*AW  per-channel read address within the read bank.
- o_rd_data  out  NUM_CH*DATA_W  per-channel read data.
- o_frame_ready  out  1  read bank holds a complete frame.
- o_rd_bank  out  1  index of the current read bank (debug).
- i_frame_release  in  1  single-cycle pulse; reader is finished with the read bank.
- o_overflow  out  1  sticky: a write was attempted while not ready.

Behaviour:
- State:
  - wr_bank, rd_bank: 1 bit each.
  - full[1:0]: per-bank full flags.
  - per-channel write counters wcnt[c], range 0..FRAME_LEN.
  - ch_done[c] = (wcnt[c] == FRAME_LEN).
- Reset values: wr_bank = rd_bank = 0, full = 0, wcnt = 0, o_overflow = 0, o_frame_ready = 0, o_rd_data = 0.
- Write acceptance:
  - o_wr_ready[c] = !full[wr_bank] && !ch_done[c].
  - On i_wr_valid[c] && o_wr_ready[c]: store line at {wr_bank, wcnt[c]}, then wcnt[c]++.
- Channels fill independently. A channel that is done holds ready low until commit.
- Commit: the cycle after all ch_done are set:
  - full[wr_bank] <= 1;
  - wr_bank toggles;
  - all wcnt clear to 0.
  - No write is accepted in the commit cycle, because every ready is already low.
- o_frame_ready = full[rd_bank]. It is registered and asserts 1 cycle after commit when rd_bank == committed bank.
- Release: i_frame_release && full[rd_bank] clears full[rd_bank] and toggles rd_bank.
  - A release pulse while o_frame_ready = 0 is ignored, with no state change.
- Simultaneous commit and release in the same cycle: both take effect. They always target different banks, because the write bank is never full.
- Both banks full: all o_wr_ready are low until a release arrives. The writer stalls with no data loss.
- Read:
  - o_rd_data[c] = mem[c][{rd_bank, i_rd_addr[c]}].
  - Latency is 1 cycle, from a registered synchronous-read RAM.
  - rd_bank is sampled at the address cycle.
  - i_rd_addr ≥ FRAME_LEN returns undefined data and changes no state.
- Overflow: i_wr_valid[c] && !o_wr_ready[c] sets o_overflow. The data is dropped and no counter changes. Only reset clears o_overflow.
- Reset mid-frame: all bookkeeping clears, and partial frames are discarded. RAM contents are not cleared.

Optional Feature:
- QKV_BUF_OUTREG_EN defined:
  - an extra output register stage is added on o_rd_data;
  - read latency becomes 2 cycles;
  - o_frame_ready is unchanged.
- QKV_BUF_OUTREG_EN undefined: read latency is 1 cycle.
- The bench reads the latency from the macro.

Decomposition:
- Shared package/include: default DATA_W expression (2*SYSTOLIC_UNIT_NUM*TIME_STEPS), default FRAME_LEN (768), QKV channel index constants (Q=0, K=1, V=2).
- Sub-module spike_bank_ram:
  - simple dual-port, DATA_W × 2*2**AW, one write port and one registered read port;
  - instantiated NUM_CH times;
  - bank bit is the address MSB.
- Control logic (counters, full flags, bank pointers) lives in the top module.

Test Plan:
- All channels valid for 4 lines with FRAME_LEN=4 → commit on cycle 5; o_frame_ready=1 on cycle 6; reading addr 0..3 returns the written lines 1 cycle later (2 with QKV_BUF_OUTREG_EN).
- Q writes 4 lines, K 2, V 0, with FRAME_LEN=4 → o_wr_ready=3'b110 and no commit; after K and V complete, commit occurs and o_wr_ready returns to 3'b111.
- Two full frames written with no release → o_wr_ready=0; valid held high sets o_overflow=1; a release pulse restores ready within 1 cycle and rd_bank=1.
- Release asserted in the same cycle as the second frame's commit → full=2'b10 afterwards, rd_bank=1, o_frame_ready stays 1.
- Release pulse with o_frame_ready=0 → no change in rd_bank or full.
- s_rst asserted mid-frame after 2 of 4 lines → all counters 0, o_frame_ready=0, o_overflow=0; the next frame commits normally after 4 lines.
